// File: rtl/spi_fifo_tx.sv
// spi_fifo_tx: SPI mode-0 master transmitter draining a first-word-fallthrough FIFO.
// A frame of `length` words is sent MSB-first under chip select. An empty FIFO at a
// word boundary parks SCK low with CS still asserted until a word is available.
module spi_fifo_tx #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 2,
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_BITS-1:0] length,
  output logic                busy,
  output logic                done,
  input  logic                data_available,
  input  logic [WIDTH-1:0]    read_data,
  output logic                read_strobe,
  output logic                spi_cs_n,
  output logic                spi_sck,
  output logic                spi_mosi
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DIV_W-1:0]    DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0]    DIV_ZERO   = DIV_W'(0);
  localparam logic [BIT_W-1:0]    BIT_RELOAD = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]    BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0]    BIT_ZERO   = BIT_W'(0);
  localparam logic [LEN_BITS-1:0] LEN_ONE    = LEN_BITS'(1);
  localparam logic [LEN_BITS-1:0] LEN_ZERO   = LEN_BITS'(0);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_CS_HOLD  = 3'd4;

  logic [2:0]          state_q,     state_d;
  logic [LEN_BITS-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0]    div_cnt_q,   div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [WIDTH-1:0]    shreg_q,     shreg_d;
  logic                cs_n_q,      cs_n_d;
  logic                sck_q,       sck_d;
  logic                mosi_q,      mosi_d;
  logic                done_q,      done_d;
  logic                busy_q,      busy_d;
  logic [WIDTH-1:0]    shifted_s;

  // The FIFO is popped only while waiting in LOAD and a word is actually present.
  assign read_strobe = (state_q == ST_LOAD) && data_available;

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;

  // Next-state and datapath logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    shifted_s   = shreg_q << 1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != LEN_ZERO) begin
            remaining_d = length;
            cs_n_d      = 1'b0;
            div_cnt_d   = DIV_RELOAD;
            state_d     = ST_CS_SETUP;
          end else begin
            // Empty frame: acknowledge immediately without touching the bus.
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CS_SETUP: begin
        if (div_cnt_q == DIV_ZERO) begin
          state_d = ST_LOAD;
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end

      ST_LOAD: begin
        if (data_available) begin
          shreg_d     = read_data;
          mosi_d      = read_data[WIDTH-1];
          bit_cnt_d   = BIT_RELOAD;
          remaining_d = remaining_q - LEN_ONE;
          div_cnt_d   = DIV_RELOAD;
          state_d     = ST_SHIFT;
        end else begin
          // Stall with SCK low and CS held; never send stale data.
          state_d = ST_LOAD;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_ZERO) begin
          div_cnt_d = DIV_RELOAD;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            // Rising edge: slave samples, MOSI stays put.
            mosi_d = mosi_q;
          end else if (bit_cnt_q != BIT_ZERO) begin
            // Falling edge inside a word: present the next bit.
            shreg_d   = shifted_s;
            mosi_d    = shifted_s[WIDTH-1];
            bit_cnt_d = bit_cnt_q - BIT_ONE;
          end else if (remaining_q != LEN_ZERO) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_CS_HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end

      ST_CS_HOLD: begin
        if (div_cnt_q == DIV_ZERO) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q - DIV_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset to the idle bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= LEN_ZERO;
      div_cnt_q   <= DIV_ZERO;
      bit_cnt_q   <= BIT_ZERO;
      shreg_q     <= {WIDTH{1'b0}};
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_fifo_tx.sv
// tb_spi_fifo_tx: directed bench for spi_fifo_tx with two instances (DIV=2 and DIV=1),
// each fed by a small FWFT FIFO model and watched by an SPI receiver model.
module tb_spi_fifo_tx;

  logic        clk;
  logic        reset;
  logic        start_a  [2];
  logic [15:0] len_a    [2];
  logic        busy_a   [2];
  logic        done_a   [2];
  logic        avail_a  [2];
  logic [7:0]  rdata_a  [2];
  logic        strobe_a [2];
  logic        cs_n_a   [2];
  logic        sck_a    [2];
  logic        mosi_a   [2];

  // FIFO models
  logic [7:0]  fmem   [2][16];
  logic [3:0]  wr_ptr [2];
  logic [3:0]  rd_ptr [2];

  // Monitor state
  logic        sck_prev   [2];
  logic [6:0]  rx_sr      [2];
  int          rx_bits    [2];
  int          rx_n       [2];
  logic [7:0]  rx_mem     [2][64];
  int          strobe_cnt [2];
  int          bad_cnt    [2];
  int          done_cnt   [2];
  int          busy_cnt   [2];
  int          cs_low_cnt [2];
  int          rise_cnt   [2];

  int checks;
  int errors;

  spi_fifo_tx #(.WIDTH(8), .DIV(2), .LEN_BITS(16)) dut0 (
    .clk(clk), .reset(reset), .start(start_a[0]), .length(len_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .data_available(avail_a[0]),
    .read_data(rdata_a[0]), .read_strobe(strobe_a[0]), .spi_cs_n(cs_n_a[0]),
    .spi_sck(sck_a[0]), .spi_mosi(mosi_a[0])
  );

  spi_fifo_tx #(.WIDTH(8), .DIV(1), .LEN_BITS(16)) dut1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .length(len_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .data_available(avail_a[1]),
    .read_data(rdata_a[1]), .read_strobe(strobe_a[1]), .spi_cs_n(cs_n_a[1]),
    .spi_sck(sck_a[1]), .spi_mosi(mosi_a[1])
  );

  assign avail_a[0] = (wr_ptr[0] != rd_ptr[0]);
  assign avail_a[1] = (wr_ptr[1] != rd_ptr[1]);
  assign rdata_a[0] = fmem[0][rd_ptr[0]];
  assign rdata_a[1] = fmem[1][rd_ptr[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO pop side plus SPI receiver and event counters for both instances.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sck_prev[k] <= sck_a[k];
      if (strobe_a[k]) begin
        strobe_cnt[k] <= strobe_cnt[k] + 1;
        rd_ptr[k]     <= rd_ptr[k] + 4'd1;
        if (!avail_a[k]) bad_cnt[k] <= bad_cnt[k] + 1;
      end
      if (done_a[k])  done_cnt[k]   <= done_cnt[k] + 1;
      if (busy_a[k])  busy_cnt[k]   <= busy_cnt[k] + 1;
      if (!cs_n_a[k]) cs_low_cnt[k] <= cs_low_cnt[k] + 1;
      if (cs_n_a[k] && sck_a[k]) bad_cnt[k] <= bad_cnt[k] + 1;
      if (cs_n_a[k]) begin
        rx_bits[k] <= 0;
      end else if (sck_a[k] && !sck_prev[k]) begin
        rise_cnt[k] <= rise_cnt[k] + 1;
        if (rx_bits[k] == 7) begin
          rx_mem[k][rx_n[k] % 64] <= {rx_sr[k], mosi_a[k]};
          rx_n[k]    <= rx_n[k] + 1;
          rx_bits[k] <= 0;
        end else begin
          rx_sr[k]   <= {rx_sr[k][5:0], mosi_a[k]};
          rx_bits[k] <= rx_bits[k] + 1;
        end
      end
    end
  end

  typedef struct {
    int          inst;
    int          len;
    int          npush;
    logic [31:0] push;   // byte i at [8*i +: 8]
    logic [31:0] expw;   // expected received bytes, same layout
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    @(negedge clk);
    fmem[inst][wr_ptr[inst]] = b;
    wr_ptr[inst] = wr_ptr[inst] + 4'd1;
  endtask

  // Issue start and count edges from the accepting edge until done is seen.
  task automatic run_frame(input int inst, input int len, output int cyc);
    @(negedge clk);
    start_a[inst] = 1'b1;
    len_a[inst]   = len[15:0];
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      start_a[inst] = 1'b0;
    end while (!done_a[inst] && cyc < 3000);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  int cyc;
  int b_strobe, b_done, b_busy, b_cs, b_rise, b_bad, b_rx;
  logic [31:0] pw;
  logic [31:0] ew;

  task automatic snap(input int inst);
    b_strobe = strobe_cnt[inst];
    b_done   = done_cnt[inst];
    b_busy   = busy_cnt[inst];
    b_cs     = cs_low_cnt[inst];
    b_rise   = rise_cnt[inst];
    b_bad    = bad_cnt[inst];
    b_rx     = rx_n[inst];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_a[k] = 1'b0; len_a[k] = 16'd0; wr_ptr[k] = 4'd0; rd_ptr[k] = 4'd0;
      sck_prev[k] = 1'b0; rx_sr[k] = 7'd0; rx_bits[k] = 0; rx_n[k] = 0;
      strobe_cnt[k] = 0; bad_cnt[k] = 0; done_cnt[k] = 0; busy_cnt[k] = 0;
      cs_low_cnt[k] = 0; rise_cnt[k] = 0;
      for (int j = 0; j < 16; j++) fmem[k][j] = 8'h00;
    end

    // inst, len, npush, push bytes, expected bytes, edges until done seen
    vecs[0] = '{0, 2, 2, {8'h00, 8'h00, 8'h3C, 8'hA5}, {8'h00, 8'h00, 8'h3C, 8'hA5}, 71};
    vecs[1] = '{0, 0, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 32'h0, 1};
    vecs[2] = '{0, 1, 0, 32'h0, {8'h00, 8'h00, 8'h00, 8'h5A}, 38};
    vecs[3] = '{0, 3, 3, {8'h00, 8'h7E, 8'h81, 8'h00}, {8'h00, 8'h7E, 8'h81, 8'h00}, 104};
    vecs[4] = '{1, 4, 4, {8'h80, 8'h01, 8'hFF, 8'h00}, {8'h80, 8'h01, 8'hFF, 8'h00}, 71};
    vecs[5] = '{1, 1, 1, {8'h00, 8'h00, 8'h00, 8'hC3}, {8'h00, 8'h00, 8'h00, 8'hC3}, 20};

    wait_cycles(3);
    for (int k = 0; k < 2; k++) begin
      chk("reset_cs_n",   {31'd0, cs_n_a[k]},   32'd1);
      chk("reset_sck",    {31'd0, sck_a[k]},    32'd0);
      chk("reset_mosi",   {31'd0, mosi_a[k]},   32'd0);
      chk("reset_busy",   {31'd0, busy_a[k]},   32'd0);
      chk("reset_done",   {31'd0, done_a[k]},   32'd0);
      chk("reset_strobe", {31'd0, strobe_a[k]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      pw = vecs[v].push;
      ew = vecs[v].expw;
      for (int i = 0; i < vecs[v].npush; i++) push(vecs[v].inst, pw[8*i +: 8]);
      snap(vecs[v].inst);
      run_frame(vecs[v].inst, vecs[v].len, cyc);
      wait_cycles(1);
      chk("frame_cycles", cyc, vecs[v].exp_cyc);
      chk("done_pulses",  done_cnt[vecs[v].inst] - b_done, 1);
      chk("strobes",      strobe_cnt[vecs[v].inst] - b_strobe, vecs[v].len);
      chk("busy_cycles",  busy_cnt[vecs[v].inst] - b_busy, vecs[v].exp_cyc - 1);
      chk("cs_low",       cs_low_cnt[vecs[v].inst] - b_cs, vecs[v].exp_cyc - 1);
      chk("sck_rises",    rise_cnt[vecs[v].inst] - b_rise, 8 * vecs[v].len);
      chk("violations",   bad_cnt[vecs[v].inst] - b_bad, 0);
      for (int i = 0; i < vecs[v].len; i++)
        chk("rx_word", rx_mem[vecs[v].inst][(b_rx + i) % 64], ew[8*i +: 8]);
    end

    // Stall on empty FIFO: three words trickled in every 50 clocks
    snap(0);
    @(negedge clk);
    start_a[0] = 1'b1;
    len_a[0]   = 16'd3;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    wait_cycles(20);
    chk("stall_cs_n",    {31'd0, cs_n_a[0]}, 32'd0);
    chk("stall_sck",     {31'd0, sck_a[0]},  32'd0);
    chk("stall_busy",    {31'd0, busy_a[0]}, 32'd1);
    chk("stall_strobes", strobe_cnt[0] - b_strobe, 0);
    push(0, 8'hA1);
    wait_cycles(50);
    chk("gap_cs_n",    {31'd0, cs_n_a[0]}, 32'd0);
    chk("gap_sck",     {31'd0, sck_a[0]},  32'd0);
    chk("gap_strobes", strobe_cnt[0] - b_strobe, 1);
    push(0, 8'hB2);
    wait_cycles(50);
    push(0, 8'hC3);
    cyc = 0;
    while (!done_a[0] && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    wait_cycles(1);
    chk("stall_done",     done_cnt[0] - b_done, 1);
    chk("stall_strobes3", strobe_cnt[0] - b_strobe, 3);
    chk("stall_viol",     bad_cnt[0] - b_bad, 0);
    chk("stall_w0", rx_mem[0][(b_rx + 0) % 64], 8'hA1);
    chk("stall_w1", rx_mem[0][(b_rx + 1) % 64], 8'hB2);
    chk("stall_w2", rx_mem[0][(b_rx + 2) % 64], 8'hC3);

    // Reset in the middle of the second word, then a clean one-word frame
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    snap(0);
    @(negedge clk);
    start_a[0] = 1'b1;
    len_a[0]   = 16'd2;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    cyc = 0;
    while ((strobe_cnt[0] - b_strobe) < 2 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    wait_cycles(8);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_cs_n", {31'd0, cs_n_a[0]}, 32'd1);
    chk("rst_mid_sck",  {31'd0, sck_a[0]},  32'd0);
    chk("rst_mid_busy", {31'd0, busy_a[0]}, 32'd0);
    chk("rst_mid_mosi", {31'd0, mosi_a[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(4);
    chk("rst_mid_strobes", strobe_cnt[0] - b_strobe, 2);
    chk("rst_mid_done",    done_cnt[0] - b_done, 0);
    snap(0);
    run_frame(0, 1, cyc);
    wait_cycles(1);
    chk("post_rst_cycles",  cyc, 38);
    chk("post_rst_strobes", strobe_cnt[0] - b_strobe, 1);
    chk("post_rst_rxn",     rx_n[0] - b_rx, 1);
    chk("post_rst_word",    rx_mem[0][b_rx % 64], 8'h33);

    // Second start while busy must be ignored
    push(0, 8'h12);
    push(0, 8'h34);
    snap(0);
    @(negedge clk);
    start_a[0] = 1'b1;
    len_a[0]   = 16'd2;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    cyc = 1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start_a[0] = 1'b1;
    len_a[0]   = 16'd5;
    @(posedge clk);
    #1;
    cyc++;
    start_a[0] = 1'b0;
    while (!done_a[0] && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    wait_cycles(10);
    chk("ignore_cycles",  cyc, 71);
    chk("ignore_done",    done_cnt[0] - b_done, 1);
    chk("ignore_strobes", strobe_cnt[0] - b_strobe, 2);
    chk("ignore_busy",    {31'd0, busy_a[0]}, 32'd0);
    chk("ignore_w0",      rx_mem[0][(b_rx + 0) % 64], 8'h12);
    chk("ignore_w1",      rx_mem[0][(b_rx + 1) % 64], 8'h34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
